// File: rtl/mem_pkg.sv
// Shared definitions for the store buffer and its FIFO: states, size encodings, entry layout.
package mem_pkg;

    localparam int unsigned DEFAULT_DEPTH = 4;
    localparam int unsigned ADDR_W        = 32;
    localparam int unsigned DATA_W        = 32;
    localparam int unsigned MASK_W        = 4;

    localparam logic [2:0] SM_BYTE = 3'b001;
    localparam logic [2:0] SM_HALF = 3'b011;
    localparam logic [2:0] SM_WORD = 3'b111;

    localparam logic [ADDR_W-1:0] LED_ADDR = 32'h0000_2000;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_LOAD_WAIT  = 2'd1,
        ST_STORE_WAIT = 2'd2,
        ST_LOAD_DONE  = 2'd3
    } sb_state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic [MASK_W-1:0] sign_mask;
    } sb_entry_t;

endpackage

// File: rtl/store_fifo.sv
// Circular store queue with full/empty flags and a word-address hit check over all live entries.
module store_fifo
    import mem_pkg::*;
#(
    parameter int unsigned DEPTH = DEFAULT_DEPTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic              pop,
    input  sb_entry_t         wr_entry,
    input  logic [29:0]       cmp_word,
    output sb_entry_t         head,
    output logic              full,
    output logic              empty,
    output logic              conflict
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    sb_entry_t        mem [DEPTH];
    logic [PTR_W-1:0] head_ptr;
    logic [PTR_W-1:0] tail_ptr;
    logic [CNT_W-1:0] count;
    logic [PTR_W-1:0] offs;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_ptr <= '0;
            tail_ptr <= '0;
            count    <= '0;
        end else begin
            if (push) tail_ptr <= tail_ptr + PTR_W'(1);
            if (pop)  head_ptr <= head_ptr + PTR_W'(1);
            if (push && !pop)      count <= count + CNT_W'(1);
            else if (pop && !push) count <= count - CNT_W'(1);
        end
    end

    // Payload storage needs no reset: liveness comes from the pointers.
    always_ff @(posedge clk) begin
        if (push) mem[tail_ptr] <= wr_entry;
    end

    assign head  = mem[head_ptr];
    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);

    // A slot is live when its distance from head is below the occupancy.
    always_comb begin
        conflict = 1'b0;
        offs     = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            offs = PTR_W'(i) - head_ptr;
            if ((CNT_W'(offs) < count) && (mem[PTR_W'(i)].addr[31:2] == cmp_word))
                conflict = 1'b1;
        end
    end

endmodule

// File: rtl/store_buffer.sv
// Store buffer between the memory stage and the data cache; loads win the port over draining stores.
module store_buffer
    import mem_pkg::*;
#(
    parameter int unsigned DEPTH = DEFAULT_DEPTH
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_write_data,
    input  logic        cpu_memwrite,
    input  logic        cpu_memread,
    input  logic [3:0]  cpu_sign_mask,
    output logic [31:0] cpu_read_data,
    output logic        cpu_stall,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_write_data,
    output logic        mem_memwrite,
    output logic        mem_memread,
    output logic [3:0]  mem_sign_mask,
    input  logic [31:0] mem_read_data,
    input  logic        mem_stall
);

    sb_state_t state;
    sb_entry_t wr_entry;
    sb_entry_t head;
    logic      full;
    logic      empty;
    logic      conflict;
    logic      push;
    logic      pop;
    logic      idle_ok;
    logic      issue_load;
    logic      issue_store;

    assign wr_entry = '{addr: cpu_addr, data: cpu_write_data, sign_mask: cpu_sign_mask};

    store_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push),
        .pop      (pop),
        .wr_entry (wr_entry),
        .cmp_word (cpu_addr[31:2]),
        .head     (head),
        .full     (full),
        .empty    (empty),
        .conflict (conflict)
    );

    // Requests are gated by rst_n: the cache is not reset and must never see one during reset.
    assign idle_ok     = rst_n && (state == ST_IDLE) && !mem_stall;
    assign issue_load  = idle_ok && cpu_memread && !conflict;
    assign issue_store = idle_ok && !(cpu_memread && !conflict) && !empty;
    assign pop         = (state == ST_STORE_WAIT) && !mem_stall;

    assign cpu_stall = (cpu_memread && (state != ST_LOAD_DONE))
                     || (cpu_memwrite && !cpu_memread && full && !pop);
    assign push      = cpu_memwrite && !cpu_memread && !cpu_stall;

    assign mem_memread    = issue_load;
    assign mem_memwrite   = issue_store;
    assign mem_addr       = issue_load ? cpu_addr       : head.addr;
    assign mem_write_data = issue_load ? cpu_write_data : head.data;
    assign mem_sign_mask  = issue_load ? cpu_sign_mask  : head.sign_mask;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            cpu_read_data <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (issue_load)       state <= ST_LOAD_WAIT;
                    else if (issue_store) state <= ST_STORE_WAIT;
                end
                ST_LOAD_WAIT: begin
                    if (!mem_stall) begin
                        cpu_read_data <= mem_read_data;
                        state         <= ST_LOAD_DONE;
                    end
                end
                ST_STORE_WAIT: begin
                    if (pop) state <= ST_IDLE;
                end
                ST_LOAD_DONE: state <= ST_IDLE;
                default:      state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_store_buffer.sv
// Bench for store_buffer: cache model with a 2-cycle busy window, program-order memory reference.
module tb_store_buffer;
    import mem_pkg::*;

    localparam int unsigned DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_write_data;
    logic        cpu_memwrite;
    logic        cpu_memread;
    logic [3:0]  cpu_sign_mask;
    logic [31:0] cpu_read_data;
    logic        cpu_stall;
    logic [31:0] mem_addr;
    logic [31:0] mem_write_data;
    logic        mem_memwrite;
    logic        mem_memread;
    logic [3:0]  mem_sign_mask;
    logic [31:0] mem_read_data = '0;
    logic        mem_stall;

    store_buffer #(.DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .cpu_addr       (cpu_addr),
        .cpu_write_data (cpu_write_data),
        .cpu_memwrite   (cpu_memwrite),
        .cpu_memread    (cpu_memread),
        .cpu_sign_mask  (cpu_sign_mask),
        .cpu_read_data  (cpu_read_data),
        .cpu_stall      (cpu_stall),
        .mem_addr       (mem_addr),
        .mem_write_data (mem_write_data),
        .mem_memwrite   (mem_memwrite),
        .mem_memread    (mem_memread),
        .mem_sign_mask  (mem_sign_mask),
        .mem_read_data  (mem_read_data),
        .mem_stall      (mem_stall)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  mask;
    } wr_t;

    logic [31:0] cmem [0:4095];
    logic [31:0] arch [0:4095];
    int unsigned busy = 0;
    wr_t         exp_wr [$];
    logic        ev_kind [$];
    logic [31:0] ev_addr [$];

    function automatic int widx(input logic [31:0] a);
        return int'(a[13:2]);
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [1:0] off,
                                          input logic [31:0] d, input logic [3:0] m);
        logic [31:0] r;
        r = old;
        case (m[2:0])
            SM_BYTE: r[8*off +: 8]     = d[7:0];
            SM_HALF: r[16*off[1] +: 16] = d[15:0];
            default: r = d;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] extract(input logic [31:0] w, input logic [1:0] off,
                                            input logic [3:0] m);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[8*off +: 8];
        h = w[16*off[1] +: 16];
        case (m[2:0])
            SM_BYTE: return m[3] ? {{24{b[7]}}, b} : {24'h0, b};
            SM_HALF: return m[3] ? {{16{h[15]}}, h} : {16'h0, h};
            default: return w;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Cache model: samples a request, busy for two cycles, read data ready when busy drops.
    always @(posedge clk) begin
        wr_t w;
        if (mem_memread || mem_memwrite) begin
            chk("no_issue_while_busy", 32'(busy), 32'd0);
            chk("rd_wr_exclusive", 32'(mem_memread & mem_memwrite), 32'd0);
        end
        if (busy != 0) begin
            busy <= busy - 1;
        end else if (mem_memread) begin
            busy          <= 2;
            mem_read_data <= extract(cmem[widx(mem_addr)], mem_addr[1:0], mem_sign_mask);
            ev_kind.push_back(1'b0);
            ev_addr.push_back(mem_addr);
        end else if (mem_memwrite) begin
            busy <= 2;
            cmem[widx(mem_addr)] <= merge(cmem[widx(mem_addr)], mem_addr[1:0], mem_write_data, mem_sign_mask);
            ev_kind.push_back(1'b1);
            ev_addr.push_back(mem_addr);
            chk("write_expected", 32'(exp_wr.size() != 0), 32'd1);
            if (exp_wr.size() != 0) begin
                w = exp_wr.pop_front();
                chk("wr_addr", mem_addr, w.addr);
                chk("wr_data", mem_write_data, w.data);
                chk("wr_mask", 32'(mem_sign_mask), 32'(w.mask));
            end
        end
    end

    assign mem_stall = (busy != 0);

    // One CPU memory op, held while stalled; returns stall cycles and the read data after accept.
    task automatic cpu_op(input logic rd, input logic wr, input logic [31:0] a,
                          input logic [31:0] d, input logic [3:0] m,
                          output int stalls, output logic [31:0] rdata);
        @(negedge clk);
        cpu_memread    = rd;
        cpu_memwrite   = wr;
        cpu_addr       = a;
        cpu_write_data = d;
        cpu_sign_mask  = m;
        stalls         = 0;
        #1;
        while (cpu_stall && stalls < 200) begin
            stalls++;
            @(negedge clk);
            #1;
        end
        if (cpu_stall) chk("op_timeout", 32'd1, 32'd0);
        @(posedge clk);
        if (wr && !rd) begin
            arch[widx(a)] = merge(arch[widx(a)], a[1:0], d, m);
            exp_wr.push_back({a, d, m});
        end
        #1;
        rdata        = cpu_read_data;
        cpu_memread  = 1'b0;
        cpu_memwrite = 1'b0;
    endtask

    task automatic drain();
        int k;
        k = 0;
        while ((exp_wr.size() != 0 || busy != 0) && k < 500) begin
            @(negedge clk);
            k++;
        end
        chk("drain_done", 32'(exp_wr.size()), 32'd0);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        int          st;
        logic [31:0] rd;
        int          mark;
        int          nw;
        int          exp_st [6];
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  m;
        int          sz;

        exp_st = '{0, 0, 0, 0, 0, 3};
        rst_n = 1'b0;
        cpu_memread = 1'b0; cpu_memwrite = 1'b0;
        cpu_addr = '0; cpu_write_data = '0; cpu_sign_mask = 4'b0111;
        repeat (3) @(negedge clk);
        chk("rst_read_data", cpu_read_data, 32'h0);
        chk("rst_memread", 32'(mem_memread), 32'd0);
        chk("rst_memwrite", 32'(mem_memwrite), 32'd0);
        chk("rst_stall_idle", 32'(cpu_stall), 32'd0);
        cpu_memread = 1'b1;
        #1;
        chk("rst_stall_follows", 32'(cpu_stall), 32'd1);
        chk("rst_no_issue", 32'(mem_memread), 32'd0);
        cpu_memread = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // Single load from an otherwise empty buffer.
        cpu_op(1'b0, 1'b1, 32'h1004, 32'hDEADBEEF, 4'b0111, st, rd);
        chk("store_no_stall", 32'(st), 32'd0);
        drain();
        cpu_op(1'b1, 1'b0, 32'h1004, 32'h0, 4'b0111, st, rd);
        chk("load_stall_cycles", 32'(st), 32'd4);
        chk("load_data", rd, 32'hDEADBEEF);

        // Six back-to-back stores: fill, push on the pop edge while full, then a real full stall.
        for (int i = 0; i < 6; i++) begin
            cpu_op(1'b0, 1'b1, 32'h1000 + 32'(4 * i), 32'hA000_0000 + 32'(i), 4'b0111, st, rd);
            chk($sformatf("burst_stall_%0d", i), 32'(st), 32'(exp_st[i]));
        end
        drain();

        // Load hitting a queued store's word waits for it to drain.
        cpu_op(1'b0, 1'b1, 32'h1008, 32'h11223344, 4'b0111, st, rd);
        cpu_op(1'b1, 1'b0, 32'h100A, 32'h0, 4'b0001, st, rd);
        chk("conflict_stall_cycles", 32'(st), 32'd8);
        chk("conflict_byte", rd, 32'h22);
        drain();

        // LED store stays queued while a non-conflicting load takes the port.
        cpu_op(1'b0, 1'b1, LED_ADDR, 32'h5, 4'b0111, st, rd);
        drain();
        mark = ev_kind.size();
        cpu_op(1'b0, 1'b1, LED_ADDR, 32'hA5, 4'b0111, st, rd);
        cpu_op(1'b1, 1'b0, 32'h1000, 32'h0, 4'b0111, st, rd);
        chk("bypass_stall_cycles", 32'(st), 32'd4);
        chk("bypass_data", rd, 32'hA000_0000);
        chk("led_not_yet", cmem[widx(LED_ADDR)], 32'h5);
        chk("first_event_read", 32'(ev_kind[mark]), 32'd0);
        drain();
        chk("led_updated", cmem[widx(LED_ADDR)], 32'hA5);
        chk("second_event_addr", ev_addr[mark + 1], LED_ADDR);

        // Reset while a store is in flight with three entries queued.
        cpu_op(1'b0, 1'b1, 32'h1010, 32'h0BAD_0001, 4'b0111, st, rd);
        cpu_op(1'b0, 1'b1, 32'h1014, 32'h0BAD_0002, 4'b0111, st, rd);
        cpu_op(1'b0, 1'b1, 32'h1018, 32'h0BAD_0003, 4'b0111, st, rd);
        rst_n = 1'b0;
        exp_wr.delete();
        mark = ev_kind.size();
        @(negedge clk);
        chk("midrst_read_data", cpu_read_data, 32'h0);
        chk("midrst_memwrite", 32'(mem_memwrite), 32'd0);
        chk("midrst_stall", 32'(cpu_stall), 32'd0);
        rst_n = 1'b1;
        cpu_memread = 1'b1; cpu_addr = 32'h1010; cpu_sign_mask = 4'b0111;
        #1;
        chk("postrst_busy_no_issue", 32'(mem_memread), 32'd0);
        for (int i = 0; i < 4096; i++) arch[i] = cmem[i];
        cpu_op(1'b1, 1'b0, 32'h1010, 32'h0, 4'b0111, st, rd);
        chk("postrst_load_stall", 32'(st), 32'd4);
        chk("postrst_load_data", rd, 32'h0BAD_0001);
        repeat (10) @(negedge clk);
        nw = 0;
        for (int i = mark; i < ev_kind.size(); i++) if (ev_kind[i]) nw++;
        chk("postrst_no_writes", 32'(nw), 32'd0);

        // Randomized mix against the program-order memory image.
        for (int i = 0; i < 8; i++)
            cpu_op(1'b0, 1'b1, 32'h1000 + 32'(4 * i), $urandom, 4'b0111, st, rd);
        drain();
        for (int i = 0; i < 300; i++) begin
            sz = $urandom_range(0, 2);
            a  = 32'h1000 + 32'(4 * $urandom_range(0, 7));
            if (sz == 0)      begin a[1:0] = 2'($urandom_range(0, 3)); m = {1'b0, SM_BYTE}; end
            else if (sz == 1) begin a[1]   = 1'($urandom_range(0, 1)); m = {1'b0, SM_HALF}; end
            else              m = {1'b0, SM_WORD};
            case ($urandom_range(0, 9))
                0, 1, 2, 3: cpu_op(1'b0, 1'b1, a, $urandom, m, st, rd);
                4, 5, 6, 7: begin
                    m[3] = 1'($urandom_range(0, 1));
                    d = extract(arch[widx(a)], a[1:0], m);
                    cpu_op(1'b1, 1'b0, a, 32'h0, m, st, rd);
                    chk($sformatf("rand_load_%0d@%h", i, a), rd, d);
                end
                default: @(negedge clk);
            endcase
        end
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
